traffic_sensor_conditioner: RTL and testbench

- Upstream stage of the 4-way traffic light controller.
- Synchronises and debounces the raw vehicle-loop detectors and latches short detector pulses until the direction is served.
- Enforces a maximum green time when conflicting demand exists, by masking the served direction's demand bit.
- Drives the controller's 4-bit sensor input and consumes the controller's 3-bit state as feedback.

---
 rtl/traffic_sensor_conditioner.sv | 139 +++++++++++++
 tb/tb_traffic_sensor_conditioner.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/traffic_sensor_conditioner.sv
// ============================================================================
// Module  : traffic_sensor_conditioner
// Brief   : Synchronises, debounces and latches loop-detector demand for the
//           4-way light controller, masking served demand on max-green expiry.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module traffic_sensor_conditioner #(
  parameter int DEB_CYC   = 4,
  parameter int DEB_W     = 4,
  parameter int MAX_GREEN = 16,
  parameter int GW        = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] det_raw,
  input  logic [2:0] state,
  output logic [3:0] sensor,
  output logic [3:0] pending,
  output logic       force_yellow
);

  localparam logic [2:0]       C_ST_GR   = 3'b001;
  localparam logic [2:0]       C_ST_LR   = 3'b010;
  localparam logic [2:0]       C_ST_RG   = 3'b100;
  localparam logic [2:0]       C_ST_RL   = 3'b101;
  localparam logic [DEB_W-1:0] C_DEB_END = DEB_W'(DEB_CYC - 1);
  localparam logic [GW-1:0]    C_GMAX    = GW'(MAX_GREEN);

  logic [3:0]       sync1_q, sync2_q;
  logic [3:0]       deb_q, deb_d;
  logic [DEB_W-1:0] cnt_q [4];
  logic [DEB_W-1:0] cnt_d [4];
  logic [3:0]       rise;
  logic [3:0]       pending_q, pending_d;
  logic [GW-1:0]    gcnt_q, gcnt_d;
  logic [3:0]       yield_q, yield_d;
  logic [3:0]       sensor_q, sensor_d;
  logic             fy_q, fy_d;

  logic [3:0]       served;
  logic             serving;
  logic [3:0]       dem;
  logic             other;
  logic             expire;
  logic             entering;
  logic [3:0]       mask;

  always_comb begin
    served = 4'b0000;
    case (state)
      C_ST_GR: served = 4'b1000;
      C_ST_LR: served = 4'b0100;
      C_ST_RG: served = 4'b0010;
      C_ST_RL: served = 4'b0001;
      default: served = 4'b0000;
    endcase
  end

  assign serving = |served;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_deb
      always_comb begin
        deb_d[gi]  = deb_q[gi];
        cnt_d[gi]  = '0;
        rise[gi]   = 1'b0;
        if (sync2_q[gi] != deb_q[gi]) begin
          if (cnt_q[gi] == C_DEB_END) begin
            deb_d[gi] = sync2_q[gi];
            rise[gi]  = sync2_q[gi];
          end else begin
            cnt_d[gi] = cnt_q[gi] + 1'b1;
          end
        end
      end
    end
  endgenerate

  assign dem      = deb_q | pending_q;
  assign other    = |(dem & ~served);
  assign expire   = serving && (gcnt_q == C_GMAX) && other;
  // gcnt is zero only on the first cycle of a serving state, since serving
  // states never abut; a re-entry of the yielded direction keeps the mask.
  assign entering = serving && (gcnt_q == '0) && ((served & yield_q) == 4'b0000);
  assign mask     = yield_q | (expire ? served : 4'b0000);

  always_comb begin
    pending_d = (pending_q | rise) & ~served;

    gcnt_d = '0;
    if (serving) begin
      gcnt_d = (gcnt_q == C_GMAX) ? gcnt_q : gcnt_q + 1'b1;
    end

    yield_d = yield_q;
    if (entering || ((dem & ~yield_q) == 4'b0000)) begin
      yield_d = 4'b0000;
    end
    if (expire) begin
      yield_d = yield_d | served;
    end

    sensor_d = dem & ~mask;
    fy_d     = |(dem & mask);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      pending_q <= '0;
      gcnt_q    <= '0;
      yield_q   <= '0;
      sensor_q  <= '0;
      fy_q      <= 1'b0;
    end else begin
      sync1_q   <= det_raw;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
      pending_q <= pending_d;
      gcnt_q    <= gcnt_d;
      yield_q   <= yield_d;
      sensor_q  <= sensor_d;
      fy_q      <= fy_d;
    end
  end

  assign sensor       = sensor_q;
  assign pending      = pending_q;
  assign force_yellow = fy_q;

endmodule

`default_nettype wire

// File: tb/tb_traffic_sensor_conditioner.sv
// ============================================================================
// Module  : tb_traffic_sensor_conditioner
// Brief   : Directed bench for traffic_sensor_conditioner (default parameters).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_traffic_sensor_conditioner;

  localparam logic [2:0] RR = 3'b000, GR = 3'b001, LR = 3'b010, YR = 3'b011;
  localparam logic [2:0] RG = 3'b100, RL = 3'b101;

  logic       clk;
  logic       reset;
  logic [3:0] det_raw;
  logic [2:0] state;
  logic [3:0] sensor;
  logic [3:0] pending;
  logic       force_yellow;

  int n_pass  = 0;
  int n_total = 0;

  traffic_sensor_conditioner #(
    .DEB_CYC(4), .DEB_W(4), .MAX_GREEN(16), .GW(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .det_raw(det_raw),
    .state(state),
    .sensor(sensor),
    .pending(pending),
    .force_yellow(force_yellow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves the bench 1 time unit after the reset-release edge; next edge is edge 1.
  task automatic do_reset();
    reset   = 1'b1;
    state   = RR;
    det_raw = 4'b0000;
    tick(1);
    reset = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    state   = RR;
    det_raw = 4'b0000;
    #3;
    chk("reset_sensor", {4'b0, sensor}, 8'h00);
    chk("reset_pending", {4'b0, pending}, 8'h00);
    chk("reset_fy", {7'b0, force_yellow}, 8'h00);
    tick(2);
    reset = 1'b0;

    // 1: debounce latency
    do_reset();
    det_raw = 4'b1000;
    tick(5);
    chk("t1_sensor_e5", {4'b0, sensor}, 8'h00);
    chk("t1_pending_e5", {4'b0, pending}, 8'h00);
    tick(1);
    chk("t1_sensor_e6", {4'b0, sensor}, 8'h00);
    chk("t1_pending_e6", {4'b0, pending}, 8'h08);
    tick(1);
    chk("t1_sensor_e7", {4'b0, sensor}, 8'h08);

    // 2: glitch shorter than the debounce window
    do_reset();
    det_raw = 4'b0010;
    tick(3);
    det_raw = 4'b0000;
    tick(2);
    chk("t2_sensor_mid", {4'b0, sensor}, 8'h00);
    tick(10);
    chk("t2_sensor", {4'b0, sensor}, 8'h00);
    chk("t2_pending", {4'b0, pending}, 8'h00);

    // 3: pending holds after detector release, cleared by service
    do_reset();
    det_raw = 4'b0001;
    tick(8);
    det_raw = 4'b0000;
    tick(10);
    chk("t3_sensor_hold", {4'b0, sensor}, 8'h01);
    chk("t3_pending_hold", {4'b0, pending}, 8'h01);
    state = RL;
    tick(1);
    chk("t3_pending_clr", {4'b0, pending}, 8'h00);
    chk("t3_sensor_lag", {4'b0, sensor}, 8'h01);
    state = RR;
    tick(1);
    chk("t3_sensor_clr", {4'b0, sensor}, 8'h00);

    // 4: max-green expiry with conflicting demand
    do_reset();
    det_raw = 4'b1010;
    tick(8);
    chk("t4_sensor_pre", {4'b0, sensor}, 8'h0A);
    state = GR;
    tick(16);
    chk("t4_sensor_e16", {4'b0, sensor}, 8'h0A);
    chk("t4_fy_e16", {7'b0, force_yellow}, 8'h00);
    tick(1);
    chk("t4_sensor_e17", {4'b0, sensor}, 8'h02);
    chk("t4_fy_e17", {7'b0, force_yellow}, 8'h01);
    state = YR;
    tick(1);
    chk("t4_sensor_yr", {4'b0, sensor}, 8'h02);
    chk("t4_fy_yr", {7'b0, force_yellow}, 8'h01);
    state = RG;
    tick(2);
    chk("t4_sensor_rg", {4'b0, sensor}, 8'h0A);
    chk("t4_fy_rg", {7'b0, force_yellow}, 8'h00);

    // 5: no conflict, no expiry
    do_reset();
    det_raw = 4'b1000;
    tick(8);
    state = GR;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      chk("t5_sensor", {4'b0, sensor}, 8'h08);
      chk("t5_fy", {7'b0, force_yellow}, 8'h00);
    end

    // 6: asynchronous reset while forcing yellow
    do_reset();
    det_raw = 4'b1010;
    tick(8);
    state = GR;
    tick(17);
    chk("t6_fy_before", {7'b0, force_yellow}, 8'h01);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_sensor_rst", {4'b0, sensor}, 8'h00);
    chk("t6_pending_rst", {4'b0, pending}, 8'h00);
    chk("t6_fy_rst", {7'b0, force_yellow}, 8'h00);
    reset = 1'b0;
    state = RR;
    tick(6);
    chk("t6_sensor_e6", {4'b0, sensor}, 8'h00);
    tick(1);
    chk("t6_sensor_e7", {4'b0, sensor}, 8'h0A);

    // 7: debounced rise coinciding with service
    do_reset();
    det_raw = 4'b0100;
    tick(5);
    state = LR;
    tick(1);
    chk("t7_pending_e6", {4'b0, pending}, 8'h00);
    tick(1);
    chk("t7_sensor_e7", {4'b0, sensor}, 8'h04);
    det_raw = 4'b0000;
    tick(8);
    chk("t7_sensor_off", {4'b0, sensor}, 8'h00);
    chk("t7_pending_off", {4'b0, pending}, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
